efpga_frame_loader: RTL and testbench

Consumes the 32-bit configuration word stream (`write_data` / `write_strobe`) that the USB configuration path produces. It turns that stream into FABulous-style frame writes on the eFPGA fabric. It detects a sync word and decodes a per-frame header (column, frame index). It then gathers one word per fabric row into a frame-data register and pulses exactly one frame-strobe bit, selecting which column/frame latch captures the data. It sits between the controller's `efpga_write_data_o` / `efpga_write_strobe_o` outputs and the fabric's FrameData / FrameStrobe inputs.

---
 rtl/efpga_frame_loader.sv | 157 +++++++++++++++
 tb/tb_efpga_frame_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/efpga_frame_loader.sv
// efpga_frame_loader: turns the 32-bit configuration word stream into
// FABulous-style frame writes. A sync word arms the loader; each frame is
// then a header word (column in [7:0], frame in [15:8]) followed by one data
// word per fabric row. Once the last row word is in, the loader pulses one
// frame-strobe bit for one cycle.
//
// Ports:
//   clk_i           system clock (single domain)
//   reset_n_i       asynchronous active-low reset
//   write_data_i    configuration word
//   write_strobe_i  write_data_i valid this cycle (no backpressure)
//   frame_data_o    assembled frame data, first word in the top 32 bits
//   frame_strobe_o  one-hot frame write pulse, index = column*FRAMES_PER_COLUMN+frame
//   active_o        high while the loader is not idle
//   error_o         sticky out-of-range header flag, cleared by sync from idle
//   frame_count_o   strobes issued since the last sync (wraps)
module efpga_frame_loader #(
  parameter int unsigned NUM_ROWS          = 16,
  parameter int unsigned NUM_COLUMNS       = 10,
  parameter int unsigned FRAMES_PER_COLUMN = 20,
  parameter logic [31:0] SYNC_WORD         = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD       = 32'hFAB0_FAB0
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic [31:0]                               write_data_i,
  input  logic                                      write_strobe_i,
  output logic [32*NUM_ROWS-1:0]                    frame_data_o,
  output logic [NUM_COLUMNS*FRAMES_PER_COLUMN-1:0]  frame_strobe_o,
  output logic                                      active_o,
  output logic                                      error_o,
  output logic [15:0]                               frame_count_o
);

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned DATA_W     = WORD_W * NUM_ROWS;
  localparam int unsigned NUM_FRAMES = NUM_COLUMNS * FRAMES_PER_COLUMN;
  localparam int unsigned IDX_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned CNT_W      = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;

  logic [1:0]            state_q,   state_d;
  logic [ROW_W-1:0]      row_q,     row_d;
  logic [IDX_W-1:0]      idx_q,     idx_d;
  logic                  discard_q, discard_d;
  logic                  error_q,   error_d;
  logic [CNT_W-1:0]      count_q,   count_d;
  logic [DATA_W-1:0]     data_q,    data_d;
  logic [NUM_FRAMES-1:0] strobe_q,  strobe_d;
  logic                  active_q;

  // Header field decode
  logic [7:0] hdr_col;
  logic [7:0] hdr_frm;
  logic       hdr_in_range;
  logic       last_row;

  assign hdr_col      = write_data_i[7:0];
  assign hdr_frm      = write_data_i[15:8];
  assign hdr_in_range = (32'(hdr_col) < NUM_COLUMNS) && (32'(hdr_frm) < FRAMES_PER_COLUMN);
  assign last_row     = (row_q == ROW_W'(NUM_ROWS - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    idx_d     = idx_q;
    discard_d = discard_q;
    error_d   = error_q;
    count_d   = count_q;
    data_d    = data_q;
    strobe_d  = '0;

    if (write_strobe_i) begin
      case (state_q)
        ST_IDLE: begin
          if (write_data_i == SYNC_WORD) begin
            state_d = ST_HEADER;
            error_d = 1'b0;
            count_d = '0;
          end
        end

        ST_HEADER: begin
          if (write_data_i == DESYNC_WORD) begin
            state_d = ST_IDLE;
          end else if (write_data_i != SYNC_WORD) begin
            state_d = ST_DATA;
            row_d   = '0;
            if (hdr_in_range) begin
              idx_d     = IDX_W'(32'(hdr_col) * FRAMES_PER_COLUMN + 32'(hdr_frm));
              discard_d = 1'b0;
            end else begin
              error_d   = 1'b1;
              discard_d = 1'b1;
            end
          end
        end

        ST_DATA: begin
          // Low DATA_W bits of the concatenation = shift left by one word
          data_d = DATA_W'({data_q, write_data_i});
          if (last_row) begin
            row_d   = '0;
            state_d = ST_HEADER;
            if (!discard_q) begin
              strobe_d[idx_q] = 1'b1;
              count_d         = count_q + CNT_W'(1);
            end
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      idx_q     <= '0;
      discard_q <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
      data_q    <= '0;
      strobe_q  <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      discard_q <= discard_d;
      error_q   <= error_d;
      count_q   <= count_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      active_q  <= (state_d != ST_IDLE);
    end
  end

  assign frame_data_o   = data_q;
  assign frame_strobe_o = strobe_q;
  assign active_o       = active_q;
  assign error_o        = error_q;
  assign frame_count_o  = count_q;

endmodule

// File: tb/tb_efpga_frame_loader.sv
// Testbench for efpga_frame_loader: directed vector table plus hand-written
// sequences for the idle stream and reset in mid-frame.
module tb_efpga_frame_loader;

  localparam int unsigned NR  = 16;
  localparam int unsigned NC  = 10;
  localparam int unsigned FPC = 20;
  localparam int unsigned DW  = 32 * NR;
  localparam int unsigned NF  = NC * FPC;
  localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

  logic          clk_i;
  logic          reset_n_i;
  logic [31:0]   write_data_i;
  logic          write_strobe_i;
  logic [DW-1:0] frame_data_o;
  logic [NF-1:0] frame_strobe_o;
  logic          active_o;
  logic          error_o;
  logic [15:0]   frame_count_o;

  efpga_frame_loader #(
    .NUM_ROWS(NR), .NUM_COLUMNS(NC), .FRAMES_PER_COLUMN(FPC),
    .SYNC_WORD(SYNC), .DESYNC_WORD(DESYNC)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .write_data_i(write_data_i), .write_strobe_i(write_strobe_i),
    .frame_data_o(frame_data_o), .frame_strobe_o(frame_strobe_o),
    .active_o(active_o), .error_o(error_o), .frame_count_o(frame_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          valid;
    logic [31:0]   data;
    logic          exp_active;
    logic          exp_error;
    logic [15:0]   exp_count;
    int            exp_bit;   // -1: no strobe expected
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] model_data;
  int            tests;
  int            fails;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [NF-1:0] onehot(input int b);
    logic [NF-1:0] r;
    r = '0;
    if (b >= 0) r[b] = 1'b1;
    return r;
  endfunction

  task automatic push(input logic v, input logic [31:0] d, input logic act, input logic err,
                      input logic [15:0] cnt, input int sb, input logic chk);
    vec_t e;
    e.valid      = v;
    e.data       = d;
    e.exp_active = act;
    e.exp_error  = err;
    e.exp_count  = cnt;
    e.exp_bit    = sb;
    e.chk_data   = chk;
    e.exp_data   = model_data;
    vecs.push_back(e);
  endtask

  // One frame of NR data words; optional idle cycle before word gap_at,
  // optional sync/desync patterns embedded as words 5 and 6.
  task automatic push_frame(input logic [31:0] base, input logic err, input logic [15:0] cnt,
                            input int sb, input int gap_at, input logic inject);
    logic [31:0] w;
    for (int i = 0; i < int'(NR); i++) begin
      if (i == gap_at) push(1'b0, 32'h5A5A_5A5A, 1'b1, err, cnt, -1, 1'b0);
      w = base + 32'(i);
      if (inject && i == 5) w = DESYNC;
      if (inject && i == 6) w = SYNC;
      model_data = {model_data[DW-33:0], w};
      push(1'b1, w, 1'b1, err,
           (i == int'(NR) - 1 && sb >= 0) ? cnt + 16'd1 : cnt,
           (i == int'(NR) - 1) ? sb : -1,
           (i == int'(NR) - 1));
    end
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge clk_i);
    write_strobe_i = 1'b1;
    write_data_i   = w;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_active"}, DW'(active_o), '0);
    check({tag, "_error"},  DW'(error_o), '0);
    check({tag, "_count"},  DW'(frame_count_o), '0);
    check({tag, "_strobe"}, DW'(frame_strobe_o), '0);
    check({tag, "_data"},   frame_data_o, '0);
  endtask

  initial begin
    logic [31:0] w;
    tests          = 0;
    fails          = 0;
    reset_n_i      = 1'b0;
    write_strobe_i = 1'b0;
    write_data_i   = '0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    check_all_zero("post_reset");

    // Random words without sync are ignored
    for (int i = 0; i < 50; i++) begin
      w = $urandom;
      if (w == SYNC) w = ~w;
      send(w);
      check($sformatf("nosync%0d_active", i), DW'(active_o), '0);
      check($sformatf("nosync%0d_strobe", i), DW'(frame_strobe_o), '0);
    end

    // Build the directed table
    model_data = '0;
    push(1'b1, SYNC, 1'b1, 1'b0, 16'd0, -1, 1'b0);
    push(1'b1, 32'h0000_0302, 1'b1, 1'b0, 16'd0, -1, 1'b0);             // col 2 frame 3 -> 43
    push_frame(32'hD000_0000, 1'b0, 16'd0, 43, 7, 1'b0);
    push(1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'd1, -1, 1'b1);             // data held
    push(1'b1, DESYNC, 1'b0, 1'b0, 16'd1, -1, 1'b1);
    // Out-of-range headers set the sticky error and are discarded
    push(1'b1, SYNC, 1'b1, 1'b0, 16'd0, -1, 1'b0);
    push(1'b1, 32'h0000_000A, 1'b1, 1'b1, 16'd0, -1, 1'b0);             // column 10
    push_frame(32'hE000_0000, 1'b1, 16'd0, -1, -1, 1'b0);
    push(1'b1, 32'hABCD_0001, 1'b1, 1'b1, 16'd0, -1, 1'b0);             // col 1 frame 0 -> 20
    push_frame(32'hE100_0000, 1'b1, 16'd0, 20, -1, 1'b0);
    push(1'b1, 32'h0000_1400, 1'b1, 1'b1, 16'd1, -1, 1'b0);             // frame 20
    push_frame(32'hE200_0000, 1'b1, 16'd1, -1, -1, 1'b0);
    push(1'b1, SYNC, 1'b1, 1'b1, 16'd1, -1, 1'b0);                      // no-op in header
    push(1'b1, DESYNC, 1'b0, 1'b1, 16'd1, -1, 1'b0);
    push(1'b1, SYNC, 1'b1, 1'b0, 16'd0, -1, 1'b0);                      // clears error
    // Sync/desync patterns inside data, top index
    push(1'b1, 32'h0000_1309, 1'b1, 1'b0, 16'd0, -1, 1'b0);             // col 9 frame 19 -> 199
    push_frame(32'hC000_0000, 1'b0, 16'd0, 199, -1, 1'b1);
    // Back-to-back: header in the strobe cycle, index 0
    push(1'b1, 32'h0000_0000, 1'b1, 1'b0, 16'd1, -1, 1'b0);
    push_frame(32'hB000_0000, 1'b0, 16'd1, 0, -1, 1'b0);
    push(1'b1, DESYNC, 1'b0, 1'b0, 16'd2, -1, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      write_strobe_i = vecs[i].valid;
      write_data_i   = vecs[i].data;
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_active", i), DW'(active_o), DW'(vecs[i].exp_active));
      check($sformatf("v%0d_error", i),  DW'(error_o), DW'(vecs[i].exp_error));
      check($sformatf("v%0d_count", i),  DW'(frame_count_o), DW'(vecs[i].exp_count));
      check($sformatf("v%0d_strobe", i), DW'(frame_strobe_o), DW'(onehot(vecs[i].exp_bit)));
      if (vecs[i].chk_data) check($sformatf("v%0d_data", i), frame_data_o, vecs[i].exp_data);
    end

    // Reset in mid-frame clears everything and no strobe follows
    send(SYNC);
    send(32'h0000_0302);
    for (int i = 0; i < 8; i++) send(32'h7000_0000 + 32'(i));
    check("midframe_active", DW'(active_o), DW'(1'b1));
    @(negedge clk_i);
    write_strobe_i = 1'b0;
    #2;
    reset_n_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk_i);
    reset_n_i = 1'b1;
    for (int i = 8; i < 16; i++) begin
      send(32'h7000_0000 + 32'(i));
      check($sformatf("after_rst%0d_strobe", i), DW'(frame_strobe_o), '0);
      check($sformatf("after_rst%0d_active", i), DW'(active_o), '0);
    end
    @(negedge clk_i);
    write_strobe_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("after_rst_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
